// File: rtl/spi_flash_loader_pkg.sv
// Shared definitions for the SPI flash loader: spi_ctrl register map, bit positions,
// flash READ opcode and the loader FSM state encoding.
package spi_flash_loader_pkg;

    localparam logic [31:0] REG_CTRL   = 32'h0;
    localparam logic [31:0] REG_STATUS = 32'h4;
    localparam logic [31:0] REG_TXDATA = 32'h8;
    localparam logic [31:0] REG_RXDATA = 32'hC;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_DIV_LSB      = 1;
    localparam int CTRL_CS_FORCE_BIT = 8;

    localparam int STATUS_BUSY_BIT     = 0;
    localparam int STATUS_RX_VALID_BIT = 1;

    localparam logic [7:0] OP_READ   = 8'h03;
    localparam int         HDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_LO,
        ST_TX,
        ST_POLL,
        ST_RX,
        ST_WR,
        ST_CS_HI,
        ST_FIN
    } state_t;

    // CTRL value with the controller enabled; cs_force keeps chip select low across bytes.
    function automatic logic [31:0] ctrl_word(input logic [6:0] div, input logic cs_force);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]                    = 1'b1;
        w[CTRL_DIV_LSB +: 7]              = div;
        w[CTRL_CS_FORCE_BIT]              = cs_force;
        return w;
    endfunction

endpackage

// File: rtl/spi_flash_loader.sv
// Reads byte_len bytes from SPI flash through an spi_ctrl register block and writes them,
// packed little-endian into 32-bit words, to a destination word-write port.
module spi_flash_loader
    import spi_flash_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned POLL_LIMIT = 400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] flash_addr,
    input  logic [15:0] byte_len,
    input  logic [31:0] dst_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        m_req_valid,
    output logic        m_req_write,
    output logic [31:0] m_req_addr,
    output logic [31:0] m_req_wdata,
    output logic [3:0]  m_req_wstrb,
    input  logic [31:0] m_rdata,
    output logic        wr_valid,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_wstrb,
    input  logic        wr_ready
);

    localparam int PW = $clog2(POLL_LIMIT + 1);

    state_t        state, state_nxt;
    logic [23:0]   addr_q;
    logic [15:0]   rem_q;
    logic [2:0]    hdr_q;
    logic [1:0]    lane_q;
    logic [31:0]   wbuf_q;
    logic [3:0]    strb_q;
    logic [31:0]   waddr_q;
    logic [PW-1:0] poll_q;
    logic          error_q;

    logic       start_ok, status_ok, poll_expired, hdr_done, last_byte;
    logic [7:0] tx_byte;
    logic       unused_ok;

    assign start_ok     = (state == ST_IDLE) && start;
    assign status_ok    = !m_rdata[STATUS_BUSY_BIT] && m_rdata[STATUS_RX_VALID_BIT];
    assign poll_expired = (poll_q == PW'(POLL_LIMIT - 1));
    assign hdr_done     = (hdr_q == 3'(HDR_BYTES));
    assign last_byte    = (rem_q == 16'd1);
    assign unused_ok    = ^{m_rdata[31:8], dst_addr[1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = (byte_len == 16'd0) ? ST_FIN : ST_CS_LO;
            ST_CS_LO: state_nxt = ST_TX;
            ST_TX:    state_nxt = ST_POLL;
            ST_POLL: begin
                if (status_ok)         state_nxt = ST_RX;
                else if (poll_expired) state_nxt = ST_CS_HI;
            end
            ST_RX: begin
                if (!hdr_done)                            state_nxt = ST_TX;
                else if ((lane_q == 2'd3) || last_byte)   state_nxt = ST_WR;
                else                                      state_nxt = ST_TX;
            end
            ST_WR:    if (wr_ready) state_nxt = (rem_q == 16'd0) ? ST_CS_HI : ST_TX;
            ST_CS_HI: state_nxt = ST_FIN;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            rem_q   <= '0;
            hdr_q   <= '0;
            lane_q  <= '0;
            wbuf_q  <= '0;
            strb_q  <= '0;
            waddr_q <= '0;
            poll_q  <= '0;
            error_q <= 1'b0;
        end else begin
            if (start_ok) begin
                addr_q  <= flash_addr;
                rem_q   <= byte_len;
                hdr_q   <= '0;
                lane_q  <= '0;
                wbuf_q  <= '0;
                strb_q  <= '0;
                waddr_q <= {dst_addr[31:2], 2'b00};
                error_q <= 1'b0;
            end
            if (state == ST_TX) poll_q <= '0;
            if (state == ST_POLL) begin
                poll_q <= poll_q + 1'b1;
                if (!status_ok && poll_expired) error_q <= 1'b1;
            end
            // Header bytes only advance the header count; data bytes fill the next lane.
            if (state == ST_RX) begin
                if (!hdr_done) begin
                    hdr_q <= hdr_q + 3'd1;
                end else begin
                    wbuf_q[{lane_q, 3'b000} +: 8] <= m_rdata[7:0];
                    strb_q[lane_q]                <= 1'b1;
                    lane_q                        <= lane_q + 2'd1;
                    rem_q                         <= rem_q - 16'd1;
                end
            end
            if ((state == ST_WR) && wr_ready) begin
                wbuf_q  <= '0;
                strb_q  <= '0;
                lane_q  <= '0;
                waddr_q <= waddr_q + 32'd4;
            end
        end
    end

    always_comb begin
        unique case (hdr_q)
            3'd0:    tx_byte = OP_READ;
            3'd1:    tx_byte = addr_q[23:16];
            3'd2:    tx_byte = addr_q[15:8];
            3'd3:    tx_byte = addr_q[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        done        = (state == ST_FIN);
        error       = error_q;
        m_req_valid = 1'b0;
        m_req_write = 1'b0;
        m_req_addr  = '0;
        m_req_wdata = '0;
        m_req_wstrb = '0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        wr_wstrb    = '0;
        unique case (state)
            ST_CS_LO: begin
                m_req_valid = 1'b1;
                m_req_write = 1'b1;
                m_req_addr  = REG_CTRL;
                m_req_wdata = ctrl_word(7'(CLK_DIV), 1'b1);
                m_req_wstrb = 4'hF;
            end
            ST_TX: begin
                m_req_valid = 1'b1;
                m_req_write = 1'b1;
                m_req_addr  = REG_TXDATA;
                m_req_wdata = {24'h0, tx_byte};
                m_req_wstrb = 4'hF;
            end
            ST_POLL: begin
                m_req_valid = 1'b1;
                m_req_addr  = REG_STATUS;
            end
            ST_RX: begin
                m_req_valid = 1'b1;
                m_req_addr  = REG_RXDATA;
            end
            ST_WR: begin
                wr_valid = 1'b1;
                wr_addr  = waddr_q;
                wr_data  = wbuf_q;
                wr_wstrb = strb_q;
            end
            ST_CS_HI: begin
                m_req_valid = 1'b1;
                m_req_write = 1'b1;
                m_req_addr  = REG_CTRL;
                m_req_wdata = ctrl_word(7'(CLK_DIV), 1'b0);
                m_req_wstrb = 4'hF;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/spi_flash_loader.md
SPI_FLASH_LOADER -- requirements
Module: spi_flash_loader

Interface
REQ-001 Parameters SHALL be: CLK_DIV, default 2, SPI clock divider written to CTRL[7:1]; POLL_LIMIT, default 400, maximum STATUS polls per byte.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 start  input  1  one-cycle request, accepted only when busy=0.
REQ-005 flash_addr  input  24  flash byte address, sampled at start.
REQ-006 byte_len  input  16  number of bytes to read, sampled at start.
REQ-007 dst_addr  input  32  destination byte address, sampled at start; bits [1:0] are ignored.
REQ-008 busy  output  1  transfer in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 error  output  1  error status of the last completed transfer; holds until the next accepted start.
REQ-011 m_req_valid, m_req_write  output  1 each  single-cycle request to spi_ctrl.
REQ-012 m_req_addr  output  32, m_req_wdata  output  32, m_req_wstrb  output  4  spi_ctrl register bus.
REQ-013 m_rdata  input  32  spi_ctrl read data; valid in the same cycle as a read request and sampled at the clock edge that ends that cycle.
REQ-014 wr_valid  output  1, wr_addr  output  32, wr_data  output  32, wr_wstrb  output  4, wr_ready  input  1  word-write destination port.

Function
REQ-015 spi_ctrl register offsets SHALL be: CTRL 0x0 (bit0 spi_en, bits[7:1] clk_div, bit8 cs_force); STATUS 0x4 (bit0 busy, bit1 rx_valid); TXDATA 0x8; RXDATA 0xC.
REQ-016 Each bus request SHALL last exactly one cycle; m_req_wstrb=0xF on writes and 0x0 on reads.
REQ-017 The FSM states SHALL be IDLE, CS_LO, TX, POLL, RX, WR, CS_HI, FIN.
REQ-018 IDLE SHALL move to FIN on start with byte_len=0, with no bus traffic; start with byte_len>0 SHALL move to CS_LO.
REQ-019 CS_LO SHALL write CTRL = 0x100 | CLK_DIV<<1 | 1, then move to TX.
REQ-020 The byte sequence SHALL be 0x03, flash_addr[23:16], flash_addr[15:8], flash_addr[7:0], then byte_len bytes of 0x00.
REQ-021 TX SHALL write the next byte to TXDATA, then move to POLL.
REQ-022 POLL SHALL read STATUS once per request; busy=0 with rx_valid=1 SHALL move to RX; any other value SHALL re-poll.
REQ-023 RX SHALL read RXDATA; header-byte data SHALL be discarded; data-byte data SHALL be packed little-endian into the word buffer.
REQ-024 When 4 bytes are packed, or the last byte is packed, the FSM SHALL enter WR; otherwise it SHALL return to TX (or go to CS_HI after the last byte).
REQ-025 WR SHALL hold wr_valid, wr_addr, wr_data and wr_wstrb stable until wr_ready; unfilled lanes SHALL be zero with their strobe bits clear; wr_addr SHALL increment by 4 per word.
REQ-026 CS_HI SHALL write CTRL = CLK_DIV<<1 | 1, then move to FIN.
REQ-027 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-028 If POLL_LIMIT polls pass without completion, error SHALL be set to 1 and the FSM SHALL move to CS_HI; no further wr_valid SHALL be issued.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 The internal byte counter SHALL be 16 bits; flash address wrap is left to the flash device.

Reset
REQ-031 On rst_n low, the FSM SHALL enter IDLE and all outputs SHALL be 0, including mid-transfer; no CS_HI write SHALL be issued on reset.

Structure
REQ-032 A shared package SHALL hold the spi_ctrl register offsets, the CTRL/STATUS bit positions, the 0x03 READ opcode and the FSM state enum.
REQ-033 The module SHALL be flat with no sub-modules, instantiated beside spi_ctrl and spi_flash_model, where flash byte at address A = A[7:0].

Verification
REQ-034 4 bytes @0x000010, dst 0x100 -> one write: addr 0x100, data 0x13121110, wstrb 0xF; done=1, error=0.
REQ-035 6 bytes @0x000020, dst 0x200 -> writes 0x23222120 @0x200 strb 0xF, then 0x00002524 @0x204 strb 0x3.
REQ-036 byte_len=0 -> done one cycle after FIN entry, m_req_valid never asserted, error=0.
REQ-037 wr_ready held low 20 cycles during WR -> wr_data stable throughout, no byte lost, same final words as REQ-034.
REQ-038 STATUS stub returns busy=1 forever -> error=1 after 400 polls, last bus write CTRL=0x005, done pulses.
REQ-039 rst_n dropped during POLL, then a new start 4 bytes @0x10 -> outputs 0 during reset, then transfer completes with 0x13121110.
